// File: rtl/traffic_light_monitor_if.sv
// NS/EW light bus plus the monitor's sticky-flag and cycle-count results.
// The controller side drives the lights; the monitor receives them.
interface traffic_light_monitor_if #(
  parameter int CYC_W = 16
);
  logic [2:0]       NS_light;
  logic [2:0]       EW_light;
  logic             clr;
  logic             err_encoding;
  logic             err_conflict;
  logic             err_sequence;
  logic             err_timing;
  logic             error_any;
  logic             viol_pulse;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    output NS_light, EW_light, clr,
    input  err_encoding, err_conflict, err_sequence, err_timing,
           error_any, viol_pulse, cycle_count
  );

  modport slave (
    input  NS_light, EW_light, clr,
    output err_encoding, err_conflict, err_sequence, err_timing,
           error_any, viol_pulse, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-way traffic light: one phase tracker per direction,
// sticky encoding/conflict/sequence/timing flags and a completed-NS-cycle counter.
module tlm_tracker #(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 2,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_YELLOW = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light,
  output logic       valid,
  output logic       non_red,
  output logic       enc_err,
  output logic       seq_err,
  output logic       tim_err,
  output logic       red_to_green
);
  typedef enum logic [1:0] {S_UNK, S_RED, S_YEL, S_GRN} st_t;

  localparam logic [CNT_W-1:0] DW_MAX = '1;
  localparam logic [CNT_W-1:0] MG     = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MY     = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] XY     = CNT_W'(MAX_YELLOW);

  st_t              st;
  st_t              samp;
  logic [CNT_W-1:0] dwell;
  logic             chg;
  logic             legal;
  logic             g2y;
  logic             y2r;

  always_comb begin
    samp  = S_UNK;
    valid = 1'b1;
    case (light)
      3'b100:  samp = S_RED;
      3'b010:  samp = S_YEL;
      3'b001:  samp = S_GRN;
      default: valid = 1'b0;
    endcase
  end

  // Checks only apply to a change away from a known phase.
  assign chg          = valid && (st != S_UNK) && (samp != st);
  assign g2y          = (st == S_GRN) && (samp == S_YEL);
  assign y2r          = (st == S_YEL) && (samp == S_RED);
  assign red_to_green = chg && (st == S_RED) && (samp == S_GRN);
  assign legal        = g2y || y2r || (st == S_RED && samp == S_GRN);
  assign non_red      = valid && (samp != S_RED);
  assign enc_err      = !valid;
  assign seq_err      = chg && !legal;

  // Yellow overstay fires once, on the sample that would take dwell past the
  // bound; a saturated counter can never reach that sample.
  assign tim_err = (chg && ((g2y && dwell < MG) || (y2r && dwell < MY))) ||
                   (valid && st == S_YEL && samp == S_YEL &&
                    dwell == XY && dwell != DW_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= S_UNK;
      dwell <= '0;
    end else if (!valid) begin
      st    <= S_UNK;
      dwell <= '0;
    end else if (samp == st) begin
      if (dwell != DW_MAX) dwell <= dwell + CNT_W'(1);
    end else begin
      st    <= samp;
      dwell <= CNT_W'(1);
    end
  end
endmodule

module traffic_light_monitor #(
  parameter int MIN_GREEN  = 2,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_YELLOW = 8,
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_light_monitor_if.slave   bus
);
  localparam int NUM_DIR = 2;

  logic [NUM_DIR-1:0][2:0] lights;
  logic [NUM_DIR-1:0]      valid;
  logic [NUM_DIR-1:0]      non_red;
  logic [NUM_DIR-1:0]      enc;
  logic [NUM_DIR-1:0]      seq;
  logic [NUM_DIR-1:0]      tim;
  logic [NUM_DIR-1:0]      r2g;

  // Index 0 is NS (drives cycle_count), index 1 is EW.
  assign lights = {bus.EW_light, bus.NS_light};

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    tlm_tracker #(
      .CNT_W      (CNT_W),
      .MIN_GREEN  (MIN_GREEN),
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_YELLOW (MAX_YELLOW)
    ) u_trk (
      .clk          (clk),
      .reset        (reset),
      .light        (lights[d]),
      .valid        (valid[d]),
      .non_red      (non_red[d]),
      .enc_err      (enc[d]),
      .seq_err      (seq[d]),
      .tim_err      (tim[d]),
      .red_to_green (r2g[d])
    );
  end

  logic             new_enc, new_conf, new_seq, new_tim, cnt_inc;
  logic             f_enc, f_conf, f_seq, f_tim, viol;
  logic [CYC_W-1:0] cnt;

  assign new_enc  = |enc;
  assign new_conf = &valid && &non_red;
  assign new_seq  = |seq;
  assign new_tim  = |tim;
  assign cnt_inc  = r2g[0];

  // A violation detected in the same cycle as clr wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_enc  <= 1'b0;
      f_conf <= 1'b0;
      f_seq  <= 1'b0;
      f_tim  <= 1'b0;
      viol   <= 1'b0;
      cnt    <= '0;
    end else begin
      f_enc  <= (f_enc  && !bus.clr) || new_enc;
      f_conf <= (f_conf && !bus.clr) || new_conf;
      f_seq  <= (f_seq  && !bus.clr) || new_seq;
      f_tim  <= (f_tim  && !bus.clr) || new_tim;
      viol   <= new_enc || new_conf || new_seq || new_tim;
      if (bus.clr)                        cnt <= CYC_W'(cnt_inc);
      else if (cnt_inc && cnt != '1)      cnt <= cnt + CYC_W'(1);
    end
  end

  assign bus.err_encoding = f_enc;
  assign bus.err_conflict = f_conf;
  assign bus.err_sequence = f_seq;
  assign bus.err_timing   = f_tim;
  assign bus.error_any    = f_enc || f_conf || f_seq || f_tim;
  assign bus.viol_pulse   = viol;
  assign bus.cycle_count  = cnt;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: the driver queues hand-computed expectations per sample,
// the monitor pops one after every rising edge and compares.
module tb_traffic_light_monitor;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  typedef struct packed {
    logic        enc, conf, seq, tim, any, viol;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  e;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  sb_t  q[$];

  traffic_light_monitor_if #(.CYC_W(16)) bus ();

  traffic_light_monitor #(
    .MIN_GREEN (2), .MIN_YELLOW (1), .MAX_YELLOW (8), .CNT_W (8), .CYC_W (16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic enc, logic conf, logic seq, logic tim,
                              logic viol, int cnt);
    obs_t o;
    o.enc = enc; o.conf = conf; o.seq = seq; o.tim = tim;
    o.any = enc | conf | seq | tim;
    o.viol = viol;
    o.cnt = 16'(cnt);
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.enc  = bus.err_encoding;
    o.conf = bus.err_conflict;
    o.seq  = bus.err_sequence;
    o.tim  = bus.err_timing;
    o.any  = bus.error_any;
    o.viol = bus.viol_pulse;
    o.cnt  = bus.cycle_count;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got enc/conf/seq/tim/any/viol/cnt=%b%b%b%b%b%b/%0d expected %b%b%b%b%b%b/%0d",
               tag, act.enc, act.conf, act.seq, act.tim, act.any, act.viol, act.cnt,
               exp.enc, exp.conf, exp.seq, exp.tim, exp.any, exp.viol, exp.cnt);
    end
  endtask

  // Called at a falling edge; applies one sample and returns at the next one.
  task automatic drv(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                     input logic c, input obs_t e);
    sb_t s;
    bus.NS_light = ns;
    bus.EW_light = ew;
    bus.clr      = c;
    s.tag = tag;
    s.e   = e;
    q.push_back(s);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    int waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_drain: got %0d pending expected 0", tag, q.size());
      q.delete();
    end
    bus.clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk(tag, cur(), mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    sb_t s;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        s = q.pop_front();
        chk(s.tag, cur(), s.e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [2:0] ns, ew;
    bus.NS_light = R;
    bus.EW_light = R;
    bus.clr      = 1'b0;

    // Legal run: only the 2nd and 3rd NS greens count as completed cycles.
    do_reset("rst_init");
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 12; c++) begin
        ns = (c < 4) ? G : ((c < 6) ? Y : R);
        ew = (c < 6) ? R : ((c < 10) ? G : Y);
        drv("legal", ns, ew, 1'b0, mk(0, 0, 0, 0, 0, r));
      end
    drv("clr_with_inc", G, R, 1'b1, mk(0, 0, 0, 0, 0, 1));
    drv("after_clr_inc", G, R, 1'b0, mk(0, 0, 0, 0, 0, 1));

    do_reset("rst_conf");
    drv("conf_init", R, Y, 1'b0, mk(0, 0, 0, 0, 0, 0));
    drv("conf_hit", G, Y, 1'b0, mk(0, 1, 0, 0, 1, 1));
    drv("conf_sticky1", G, R, 1'b0, mk(0, 1, 0, 0, 0, 1));
    drv("conf_sticky2", G, R, 1'b0, mk(0, 1, 0, 0, 0, 1));
    drv("conf_clr", G, R, 1'b1, mk(0, 0, 0, 0, 0, 0));
    drv("conf_clr_wins", Y, G, 1'b1, mk(0, 1, 0, 0, 1, 0));
    drv("conf_clr_plain", R, G, 1'b1, mk(0, 0, 0, 0, 0, 0));

    do_reset("rst_seq");
    drv("seq_init", G, R, 1'b0, mk(0, 0, 0, 0, 0, 0));
    drv("seq_g2r", R, R, 1'b0, mk(0, 0, 1, 0, 1, 0));
    drv("seq_hold", R, R, 1'b0, mk(0, 0, 1, 0, 0, 0));
    drv("seq_r2y", Y, R, 1'b0, mk(0, 0, 1, 0, 1, 0));
    drv("seq_hold2", Y, R, 1'b0, mk(0, 0, 1, 0, 0, 0));

    // Yellow entered legally, then held 10 samples: 9th sample overstays.
    do_reset("rst_tim");
    drv("tim_init", G, R, 1'b0, mk(0, 0, 0, 0, 0, 0));
    drv("tim_g2", G, R, 1'b0, mk(0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      drv("tim_y_ok", Y, R, 1'b0, mk(0, 0, 0, 0, 0, 0));
    drv("tim_y9", Y, R, 1'b0, mk(0, 0, 0, 1, 1, 0));
    drv("tim_y10", Y, R, 1'b0, mk(0, 0, 0, 1, 0, 0));
    drv("tim_clr_y2r", R, R, 1'b1, mk(0, 0, 0, 0, 0, 0));
    drv("tim_r2g", G, R, 1'b0, mk(0, 0, 0, 0, 0, 1));
    drv("tim_short_g", Y, R, 1'b0, mk(0, 0, 0, 1, 1, 1));

    do_reset("rst_enc");
    drv("enc_init", G, R, 1'b0, mk(0, 0, 0, 0, 0, 0));
    drv("enc_011", 3'b011, R, 1'b0, mk(1, 0, 0, 0, 1, 0));
    drv("enc_recover", Y, R, 1'b0, mk(1, 0, 0, 0, 0, 0));
    drv("enc_hold", Y, R, 1'b0, mk(1, 0, 0, 0, 0, 0));
    drv("enc_ew_000", Y, 3'b000, 1'b0, mk(1, 0, 0, 0, 1, 0));
    drv("enc_ew_recover", Y, R, 1'b0, mk(1, 0, 0, 0, 0, 0));

    do_reset("rst_pre_async");
    drv("async_init", R, R, 1'b0, mk(0, 0, 0, 0, 0, 0));
    drv("async_conf", G, G, 1'b0, mk(0, 1, 0, 0, 1, 1));
    drv("async_short_g", Y, G, 1'b0, mk(0, 1, 0, 1, 1, 1));
    do_reset("rst_mid_yellow");
    drv("post_rst_yellow", Y, R, 1'b0, mk(0, 0, 0, 0, 0, 0));
    drv("post_rst_y2r", R, R, 1'b0, mk(0, 0, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL final_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive protocol checker for the two-way traffic light controller. It samples the NS and EW light buses every clock and tracks each direction's phase with its own state machine. It flags encoding, conflict, sequence and dwell-time violations as sticky error bits, and counts completed NS cycles. It sits beside the controller in simulation and in silicon, on the receiving end of the NS/EW light interface.

## Interface
- MIN_GREEN, 2: minimum number of sampled cycles a green must be held before going yellow
- MIN_YELLOW, 1: minimum number of sampled cycles yellow must be held before going red
- MAX_YELLOW, 8: maximum number of sampled cycles yellow may be held
- CNT_W, 8: dwell counter width; the counter saturates at 2^CNT_W-1
- CYC_W, 16: cycle_count width; saturating

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- NS_light  in  3  north-south light, one-hot {R,Y,G}: 100 red, 010 yellow, 001 green
- EW_light  in  3  east-west light, same encoding
- clr  in  1  synchronous clear of the sticky flags and cycle_count
- err_encoding  out  1  sticky: a sampled light was not one of {100,010,001}
- err_conflict  out  1  sticky: both directions were non-red in the same sample
- err_sequence  out  1  sticky: an illegal phase transition occurred
- err_timing  out  1  sticky: a dwell bound was violated
- error_any  out  1  OR of the four sticky flags (combinational from the flag registers)
- viol_pulse  out  1  one-cycle pulse for every cycle in which any new violation is detected
- cycle_count  out  CYC_W  number of completed NS red->green transitions

## Operation
- Two identical trackers, one per direction. States: UNKNOWN, RED, YELLOW, GREEN. Each tracker has a dwell counter.
- Legal transitions: GREEN->YELLOW, YELLOW->RED, RED->GREEN. Holding the same light is always legal.
- From UNKNOWN, the first valid sample loads the matching state with dwell=1. No sequence or timing check is applied to that sample.
- On each edge where the sample equals the current state: dwell increments, saturating.
- On each edge where the sample is a different valid value:
  - Check the transition for legality; if illegal, set err_sequence.
  - Load the new state with dwell=1.
- Timing checks:
  - GREEN->YELLOW with dwell < MIN_GREEN: err_timing.
  - YELLOW->RED with dwell < MIN_YELLOW: err_timing.
  - Holding YELLOW: err_timing in the cycle dwell would become MAX_YELLOW+1. It is flagged once per yellow phase, not on every later cycle.
- Invalid encoding: set err_encoding. The tracker goes to UNKNOWN with dwell=0. No sequence or timing check is made on that sample.
- Conflict: both samples valid and both non-red sets err_conflict. This is checked independently of the sequence and timing checks.
- cycle_count increments, saturating, on every legal NS RED->GREEN transition.
- A single sample can set several flags at once. viol_pulse is 1 if any check fires, including re-detection while the flag is already set.
- clr clears the four flags and cycle_count only; trackers are unaffected. If clr coincides with a new violation, the flag is set (new error wins). If clr coincides with a cycle_count increment, the result is 1.

## Timing
- Inputs are sampled at the rising edge of clk. Flags, viol_pulse and cycle_count update on that same edge, so they are visible one cycle after the offending input is presented.
- Reset (asynchronous, active-low) forces the following regardless of clk:
  - All flags = 0, viol_pulse = 0, cycle_count = 0.
  - Both trackers = UNKNOWN, dwell = 0.
- Reset released mid-phase: the first post-reset sample is treated as the initial sample, with no spurious sequence or timing error.
- The dwell counter saturates. Sequence-error behavior for a GREEN saturated hold is unchanged, and no wrap-around error occurs.

## Test plan
- **Legal run**, MIN_GREEN=2, MIN_YELLOW=1, MAX_YELLOW=8: NS G×4, Y×2, R×6 while EW R×6, G×4, Y×2, repeated 3 times -> all flags 0, viol_pulse never 1, cycle_count=2 (first NS green is the initial sample).
- **Conflict**: NS=001 and EW=001 for 1 cycle -> err_conflict=1 and viol_pulse=1 one cycle later; error_any=1; stays set until clr.
- **Sequence**: NS G then R directly -> err_sequence=1. NS R then Y -> err_sequence re-detected (viol_pulse=1 again).
- **Timing**:
  - Yellow held 9 cycles -> err_timing at the 9th sample, single viol_pulse.
  - Green held 1 cycle then Y -> err_timing.
- **Encoding/recovery**: NS=011 -> err_encoding=1. Next sample 010 -> no sequence error (tracker was UNKNOWN).
- **Reset/clear**:
  - Assert reset mid-yellow, asynchronously between edges -> flags and cycle_count are 0 immediately.
  - clr pulsed together with a conflict -> err_conflict stays 1.
